// File: rtl/pong_pkg.sv
// Shared types and playfield geometry for the pong game controller.
package pong_pkg;

  typedef enum logic [1:0] {
    StServe = 2'd0,
    StPlay  = 2'd1,
    StPoint = 2'd2,
    StOver  = 2'd3
  } game_state_t;

  typedef logic signed [11:0] coord_t;

  localparam int unsigned ScrW      = 640;
  localparam int unsigned ScrH      = 480;
  localparam int unsigned PaddleW   = 10;
  localparam int unsigned PaddleH   = 50;
  localparam int unsigned BallSz    = 8;
  localparam int unsigned P1X       = 20;
  localparam int unsigned P2X       = 610;
  localparam int unsigned PaddleV   = 3;
  localparam int unsigned BallVx    = 3;
  localparam int unsigned BallVy    = 1;
  localparam int unsigned WinScore  = 7;
  localparam int unsigned ServeHold = 30;

  localparam int unsigned BallX0     = (ScrW - BallSz) / 2;
  localparam int unsigned BallY0     = (ScrH - BallSz) / 2;
  localparam int unsigned PaddleY0   = (ScrH - PaddleH) / 2;
  localparam int unsigned PaddleYMax = ScrH - PaddleH;

  // One paddle step: up-only moves up, down-only moves down, clamped to the screen.
  function automatic logic [9:0] paddle_step(input logic [9:0] y, input logic up_n,
                                             input logic dn_n);
    logic [9:0] res;
    res = y;
    if (!up_n && dn_n) begin
      res = (y >= 10'(PaddleV)) ? y - 10'(PaddleV) : '0;
    end else if (up_n && !dn_n) begin
      res = (y >= 10'(PaddleYMax - PaddleV)) ? 10'(PaddleYMax) : y + 10'(PaddleV);
    end
    return res;
  endfunction

endpackage

// File: rtl/pong_tick_gen.sv
// Frame tick generator: one-cycle pulse every TICK_DIV clocks.
module pong_tick_gen #(
  parameter int unsigned TICK_DIV = 307200
) (
  input  logic CLOCK_50,
  input  logic reset_n,
  output logic frame_tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CntW-1:0] cnt_q;

  assign frame_tick = (cnt_q == CntW'(TICK_DIV - 1));

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (frame_tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: paddles, ball kinematics, collisions, scoring and
// serve/point/game-over flow, all advanced once per frame tick.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned TICK_DIV = 307200
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       p1_up_n,
  input  logic       p1_dn_n,
  input  logic       p2_up_n,
  input  logic       p2_dn_n,
  input  logic       serve_n,
  output logic       frame_tick,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] p1_y,
  output logic [9:0] p2_y,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] game_state
);

  localparam coord_t BallSzS  = coord_t'(BallSz);
  localparam coord_t ScrHS    = coord_t'(ScrH);
  localparam coord_t PaddleHS = coord_t'(PaddleH);
  localparam coord_t P1XS     = coord_t'(P1X);
  localparam coord_t P1Edge   = coord_t'(P1X + PaddleW);
  localparam coord_t P2XS     = coord_t'(P2X);
  localparam coord_t P2Right  = coord_t'(P2X + PaddleW);
  localparam coord_t BallVxS  = coord_t'(BallVx);
  localparam coord_t BallVyS  = coord_t'(BallVy);
  localparam logic [4:0] ServeHoldV = 5'(ServeHold);
  localparam logic [3:0] WinScoreV  = 4'(WinScore);

  game_state_t state_q;
  logic [9:0]  ball_x_q, ball_y_q, p1_y_q, p2_y_q;
  coord_t      vx_q, vy_q;
  logic [3:0]  score1_q, score2_q;
  logic        server_q;  // 0: P1 serves next, 1: P2
  logic [4:0]  holdoff_q;

  coord_t     bx, by, p1s, p2s, nx, ny;
  logic       vx_neg, vx_pos;
  logic       top_hit, bot_hit, hit1, hit2, miss_l, miss_r;
  logic [9:0] p1_next, p2_next;

  pong_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .frame_tick(frame_tick)
  );

  // Collision tests use the pre-tick paddle positions.
  always_comb begin
    bx      = coord_t'({2'b00, ball_x_q});
    by      = coord_t'({2'b00, ball_y_q});
    p1s     = coord_t'({2'b00, p1_y_q});
    p2s     = coord_t'({2'b00, p2_y_q});
    nx      = bx + vx_q;
    ny      = by + vy_q;
    vx_neg  = vx_q[11];
    vx_pos  = !vx_q[11] && (vx_q != '0);
    top_hit = ny < 12'sd0;
    bot_hit = (ny + BallSzS) > ScrHS;
    hit1    = vx_neg && (nx <= P1Edge) && (bx >= P1Edge) &&
              ((ny + BallSzS) > p1s) && (ny < (p1s + PaddleHS));
    hit2    = vx_pos && ((nx + BallSzS) >= P2XS) && ((bx + BallSzS) <= P2XS) &&
              ((ny + BallSzS) > p2s) && (ny < (p2s + PaddleHS));
    miss_l  = !hit1 && !hit2 && (nx < P1XS);
    miss_r  = !hit1 && !hit2 && ((nx + BallSzS) > P2Right);
    p1_next = paddle_step(p1_y_q, p1_up_n, p1_dn_n);
    p2_next = paddle_step(p2_y_q, p2_up_n, p2_dn_n);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q   <= StServe;
      ball_x_q  <= 10'(BallX0);
      ball_y_q  <= 10'(BallY0);
      vx_q      <= '0;
      vy_q      <= '0;
      p1_y_q    <= 10'(PaddleY0);
      p2_y_q    <= 10'(PaddleY0);
      score1_q  <= '0;
      score2_q  <= '0;
      server_q  <= 1'b0;
      holdoff_q <= '0;
    end else if (frame_tick) begin
      if (state_q != StOver) begin
        p1_y_q <= p1_next;
        p2_y_q <= p2_next;
      end
      case (state_q)
        StServe: begin
          ball_x_q <= 10'(BallX0);
          ball_y_q <= 10'(BallY0);
          vx_q     <= '0;
          vy_q     <= '0;
          if (holdoff_q != '0) begin
            holdoff_q <= holdoff_q - 5'd1;
          end else if (!serve_n) begin
            state_q <= StPlay;
            vx_q    <= server_q ? -BallVxS : BallVxS;
            vy_q    <= -BallVyS;
          end
        end
        StPlay: begin
          if (top_hit) begin
            ball_y_q <= '0;
            vy_q     <= -vy_q;
          end else if (bot_hit) begin
            ball_y_q <= 10'(ScrH - BallSz);
            vy_q     <= -vy_q;
          end else begin
            ball_y_q <= ny[9:0];
          end
          // On a miss x is left alone; the POINT tick recentres the ball.
          if (hit1) begin
            ball_x_q <= 10'(P1X + PaddleW);
            vx_q     <= BallVxS;
          end else if (hit2) begin
            ball_x_q <= 10'(P2X - BallSz);
            vx_q     <= -BallVxS;
          end else if (miss_l) begin
            if (score2_q < WinScoreV) score2_q <= score2_q + 4'd1;
            server_q <= 1'b0;
            state_q  <= StPoint;
          end else if (miss_r) begin
            if (score1_q < WinScoreV) score1_q <= score1_q + 4'd1;
            server_q <= 1'b1;
            state_q  <= StPoint;
          end else begin
            ball_x_q <= nx[9:0];
          end
        end
        StPoint: begin
          ball_x_q <= 10'(BallX0);
          ball_y_q <= 10'(BallY0);
          vx_q     <= '0;
          vy_q     <= '0;
          if ((score1_q == WinScoreV) || (score2_q == WinScoreV)) begin
            state_q <= StOver;
          end else begin
            state_q   <= StServe;
            holdoff_q <= ServeHoldV;
          end
        end
        StOver: begin
          if (!serve_n) begin
            score1_q  <= '0;
            score2_q  <= '0;
            p1_y_q    <= 10'(PaddleY0);
            p2_y_q    <= 10'(PaddleY0);
            holdoff_q <= ServeHoldV;
            state_q   <= StServe;
          end
        end
        default: state_q <= StServe;
      endcase
    end
  end

  assign ball_x     = ball_x_q;
  assign ball_y     = ball_y_q;
  assign p1_y       = p1_y_q;
  assign p2_y       = p2_y_q;
  assign score1     = score1_q;
  assign score2     = score2_q;
  assign game_state = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Randomised bench for pong_game_ctrl against a tick-level game model.
module tb_pong_game_ctrl;

  localparam int TickDiv  = 4;
  localparam int MaxFails = 50;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n  = 1'b0;
  logic       p1_up_n  = 1'b1;
  logic       p1_dn_n  = 1'b1;
  logic       p2_up_n  = 1'b1;
  logic       p2_dn_n  = 1'b1;
  logic       serve_n  = 1'b1;
  logic       frame_tick;
  logic [9:0] ball_x, ball_y, p1_y, p2_y;
  logic [3:0] score1, score2;
  logic [1:0] game_state;

  pong_game_ctrl #(
    .TICK_DIV(TickDiv)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .p1_up_n   (p1_up_n),
    .p1_dn_n   (p1_dn_n),
    .p2_up_n   (p2_up_n),
    .p2_dn_n   (p2_dn_n),
    .serve_n   (serve_n),
    .frame_tick(frame_tick),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .p1_y      (p1_y),
    .p2_y      (p2_y),
    .score1    (score1),
    .score2    (score2),
    .game_state(game_state)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_pass   = 0;
  int n_cycles = 0;
  int n_overs  = 0;

  // Model state: state 0=serve 1=play 2=point 3=over; server 1 or 2.
  int m_cnt, m_bx, m_by, m_vx, m_vy, m_p1, m_p2, m_s1, m_s2, m_st, m_server, m_hold;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, n_cycles);
  endtask

  function automatic int move_paddle(input int y, input logic up_n, input logic dn_n);
    if (!up_n && dn_n) return (y - 3 < 0) ? 0 : y - 3;
    if (up_n && !dn_n) return (y + 3 > 430) ? 430 : y + 3;
    return y;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_bx = 316; m_by = 236; m_vx = 0; m_vy = 0;
    m_p1 = 215; m_p2 = 215; m_s1 = 0; m_s2 = 0;
    m_st = 0; m_server = 1; m_hold = 0;
  endtask

  task automatic model_tick();
    int  op1, op2, nx, ny;
    bit  h1, h2;
    op1 = m_p1;
    op2 = m_p2;
    if (m_st != 3) begin
      m_p1 = move_paddle(m_p1, p1_up_n, p1_dn_n);
      m_p2 = move_paddle(m_p2, p2_up_n, p2_dn_n);
    end
    case (m_st)
      0: begin
        m_bx = 316; m_by = 236; m_vx = 0; m_vy = 0;
        if (m_hold > 0) m_hold--;
        else if (!serve_n) begin
          m_st = 1;
          m_vx = (m_server == 1) ? 3 : -3;
          m_vy = -1;
        end
      end
      1: begin
        nx = m_bx + m_vx;
        ny = m_by + m_vy;
        h1 = (m_vx < 0) && (nx <= 30) && (m_bx >= 30) && (ny + 8 > op1) && (ny < op1 + 50);
        h2 = (m_vx > 0) && (nx + 8 >= 610) && (m_bx + 8 <= 610) &&
             (ny + 8 > op2) && (ny < op2 + 50);
        if (ny < 0) begin m_by = 0; m_vy = -m_vy; end
        else if (ny + 8 > 480) begin m_by = 472; m_vy = -m_vy; end
        else m_by = ny;
        if (h1) begin m_bx = 30; m_vx = 3; end
        else if (h2) begin m_bx = 602; m_vx = -3; end
        else if (nx < 20) begin
          if (m_s2 < 7) m_s2++;
          m_server = 1; m_st = 2;
        end else if (nx + 8 > 620) begin
          if (m_s1 < 7) m_s1++;
          m_server = 2; m_st = 2;
        end else m_bx = nx;
      end
      2: begin
        m_bx = 316; m_by = 236; m_vx = 0; m_vy = 0;
        if (m_s1 == 7 || m_s2 == 7) begin m_st = 3; n_overs++; end
        else begin m_st = 0; m_hold = 30; end
      end
      default: begin
        if (!serve_n) begin
          m_s1 = 0; m_s2 = 0; m_p1 = 215; m_p2 = 215; m_hold = 30; m_st = 0;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    check_val("frame_tick", int'(frame_tick), (m_cnt == TickDiv - 1) ? 1 : 0);
    check_val("ball_x", int'(ball_x), m_bx);
    check_val("ball_y", int'(ball_y), m_by);
    check_val("p1_y", int'(p1_y), m_p1);
    check_val("p2_y", int'(p2_y), m_p2);
    check_val("score1", int'(score1), m_s1);
    check_val("score2", int'(score2), m_s2);
    check_val("game_state", int'(game_state), m_st);
  endtask

  // Inputs are stable across the posedge; the model follows the same edge.
  task automatic cycle();
    @(posedge CLOCK_50);
    if (!reset_n) model_reset();
    else begin
      if (m_cnt == TickDiv - 1) model_tick();
      m_cnt = (m_cnt + 1) % TickDiv;
    end
    @(negedge CLOCK_50);
    n_cycles++;
    compare_all();
  endtask

  task automatic set_pad(input int mode, output logic up_n, output logic dn_n);
    up_n = !(mode == 1 || mode == 3);
    dn_n = !(mode == 2 || mode == 3);
  endtask

  initial begin
    int len;
    model_reset();
    reset_n = 1'b0;
    repeat (3) cycle();
    reset_n = 1'b1;

    // Clamp at the top, then both buttons pressed must hold.
    p1_up_n = 1'b0;
    repeat (80 * TickDiv) cycle();
    p1_dn_n = 1'b0;
    repeat (10 * TickDiv) cycle();

    while (n_cycles < 60000 && (n_checks - n_pass) < MaxFails) begin
      set_pad(($urandom_range(0, 3) == 0) ? 3 : $urandom_range(0, 2), p1_up_n, p1_dn_n);
      set_pad(($urandom_range(0, 3) == 0) ? 3 : $urandom_range(0, 2), p2_up_n, p2_dn_n);
      serve_n = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) begin
        reset_n = 1'b0;
        repeat ($urandom_range(1, 3)) cycle();
        reset_n = 1'b1;
      end
      len = $urandom_range(1, 40) * TickDiv + $urandom_range(0, TickDiv - 1);
      repeat (len) cycle();
    end

    if (n_overs == 0) check_val("game_over_reached", 0, 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
